// File: rtl/gj_axis_uart_rx.sv
// gj_axis_uart_rx: oversampling UART receiver producing one valid pulse per byte plus a free-running bit_tick.
// Parity checking is built only when GJ_UART_RX_PARITY_EN is defined; otherwise frames are fixed 8N1.
module gj_axis_uart_rx #(
  parameter int OVS = 16,
  parameter int DBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      baudDiv,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             rxd,
  output logic             rx_tvalid,
  output logic [DBITS-1:0] rx_tdata,
  output logic             rx_tuser,
  output logic             bit_tick
);
  localparam int SW = $clog2(OVS);
  localparam int BW = $clog2(DBITS);
  localparam logic [SW-1:0] S_LO = SW'(OVS/2-1);
  localparam logic [SW-1:0] S_MID = SW'(OVS/2);
  localparam logic [SW-1:0] S_DEC = SW'(OVS/2+1);
  localparam logic [SW-1:0] S_MAX = SW'(OVS-1);
  localparam logic [BW-1:0] B_LAST = BW'(DBITS-1);
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAITHI
`ifdef GJ_UART_RX_PARITY_EN
    , PARITY
`endif
  } state_t;
  state_t state, nstate;
  logic s1, rxs, rxs_d, v0, v1, perr;
  logic [15:0] pc, load;
  logic [SW-1:0] sc, btc;
  logic [BW-1:0] bi;
  logic [DBITS-1:0] data;
  logic tick, fall, dec, maj;
  assign load = baudDiv > 16'd1 ? baudDiv - 16'd1 : 16'd0;
  assign tick = pc == 16'd0;
  assign fall = state == IDLE && rxs_d && !rxs;
  assign dec = tick && sc == S_DEC;
  assign maj = (v0 & v1) | (v0 & rxs) | (v1 & rxs);
`ifndef GJ_UART_RX_PARITY_EN
  logic unused_par;
  assign unused_par = parity_en ^ parity_odd;
`endif
  always_comb begin
    nstate = state;
    case (state)
      IDLE:   nstate = fall ? START : IDLE;
      START:  nstate = dec ? (maj ? IDLE : DATA) : START;
`ifdef GJ_UART_RX_PARITY_EN
      DATA:   nstate = dec && bi == B_LAST ? (parity_en ? PARITY : STOP) : DATA;
      PARITY: nstate = dec ? STOP : PARITY;
`else
      DATA:   nstate = dec && bi == B_LAST ? STOP : DATA;
`endif
      STOP:   nstate = dec ? (maj ? IDLE : WAITHI) : STOP;
      WAITHI: nstate = rxs ? IDLE : WAITHI;
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      s1 <= 1'b1;
      rxs <= 1'b1;
      rxs_d <= 1'b1;
      pc <= '0;
      sc <= '0;
      btc <= '0;
      bi <= '0;
      data <= '0;
      v0 <= 1'b0;
      v1 <= 1'b0;
      perr <= 1'b0;
      bit_tick <= 1'b0;
      rx_tvalid <= 1'b0;
      rx_tdata <= '0;
      rx_tuser <= 1'b0;
    end else begin
      state <= nstate;
      s1 <= rxd;
      rxs <= s1;
      rxs_d <= rxs;
      pc <= fall || tick ? load : pc - 16'd1;
      if (tick) btc <= btc == S_MAX ? '0 : btc + SW'(1);
      bit_tick <= tick && btc == S_MAX;
      if (fall) sc <= '0;
      else if (tick) sc <= sc == S_MAX ? '0 : sc + SW'(1);
      if (tick && sc == S_LO) v0 <= rxs;
      if (tick && sc == S_MID) v1 <= rxs;
      if (fall) bi <= '0;
      else if (dec && state == DATA) bi <= bi + BW'(1);
      if (dec && state == DATA) data[bi] <= maj;
      if (fall) perr <= 1'b0;
`ifdef GJ_UART_RX_PARITY_EN
      else if (dec && state == PARITY) perr <= maj != (parity_odd ? ~^data : ^data);
`endif
      rx_tvalid <= dec && state == STOP;
      if (dec && state == STOP) begin
        rx_tdata <= data;
        rx_tuser <= perr | ~maj;
      end
    end
  end
endmodule

// File: tb/tb_gj_axis_uart_rx.sv
// tb_gj_axis_uart_rx: vector table, hand-written corner sequences and random frames against a frame-level model.
module tb_gj_axis_uart_rx;
  localparam int OVS = 16;
  logic clk = 0, rst = 0, parity_en = 0, parity_odd = 0, rxd = 1;
  logic [15:0] baudDiv = 16'd4;
  logic rx_tvalid, rx_tuser, bit_tick;
  logic [7:0] rx_tdata;
  int checks = 0, failures = 0, cyc = 0, bt_last = -1, bt_gap = 0;
  typedef struct {logic [7:0] d; logic u; int t;} rx_t;
  typedef struct {logic [15:0] baud; logic [7:0] d; logic stop; logic [7:0] exp_d; logic exp_u;} vec_t;
  rx_t got[$];
  vec_t vecs[10];

  gj_axis_uart_rx #(.OVS(OVS), .DBITS(8)) dut (
    .clk(clk), .rst(rst), .baudDiv(baudDiv), .parity_en(parity_en), .parity_odd(parity_odd),
    .rxd(rxd), .rx_tvalid(rx_tvalid), .rx_tdata(rx_tdata), .rx_tuser(rx_tuser), .bit_tick(bit_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rx_tvalid) got.push_back('{rx_tdata, rx_tuser, cyc});
    if (bit_tick) begin
      if (bt_last >= 0) bt_gap = cyc - bt_last;
      bt_last = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int bitp();
    return OVS * (baudDiv > 16'd1 ? int'(baudDiv) : 1);
  endfunction

  task automatic drive(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input logic par, input logic pv);
    drive(1'b0, bitp());
    for (int i = 0; i < 8; i++) drive(d[i], bitp());
    if (par) drive(pv, bitp());
    drive(stop, bitp());
  endtask

  // Frame-level reference: error if stop bit is low or the parity bit breaks the requested ones-count parity.
  function automatic logic model_user(input logic [7:0] d, input logic stop, input logic par,
                                      input logic pv, input logic odd);
    int ones;
    logic want;
    ones = $countones(d);
    want = odd ? (ones % 2 == 0) : (ones % 2 == 1);
    return !stop || (par && pv != want);
  endfunction

  task automatic expect1(input string name, input logic [7:0] d, input logic u);
    chk({name, "_count"}, got.size(), 1);
    if (got.size() > 0) begin
      chk({name, "_data"}, got[0].d, d);
      chk({name, "_user"}, got[0].u, u);
    end
    got.delete();
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t0;
    logic [7:0] d;
    logic stop;
    int gap;
    vecs = '{
      '{16'd4, 8'hA5, 1'b1, 8'hA5, 1'b0}, '{16'd0, 8'h00, 1'b1, 8'h00, 1'b0},
      '{16'd1, 8'hFF, 1'b1, 8'hFF, 1'b0}, '{16'd2, 8'h55, 1'b1, 8'h55, 1'b0},
      '{16'd3, 8'hAA, 1'b1, 8'hAA, 1'b0}, '{16'd4, 8'h3C, 1'b0, 8'h3C, 1'b1},
      '{16'd4, 8'h81, 1'b1, 8'h81, 1'b0}, '{16'd0, 8'h7E, 1'b0, 8'h7E, 1'b1},
      '{16'd2, 8'h01, 1'b1, 8'h01, 1'b0}, '{16'd1, 8'h80, 1'b1, 8'h80, 1'b0}
    };
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", rx_tvalid, 0);
    chk("rst_tdata", rx_tdata, 0);
    chk("rst_tuser", rx_tuser, 0);
    chk("rst_bit_tick", bit_tick, 0);
    rst = 1;
    drive(1'b1, 300);
    chk("bit_tick_period", bt_gap, OVS * 4);
    got.delete();
    t0 = cyc;
    send(8'hA5, 1'b1, 1'b0, 1'b0);
    drive(1'b1, bitp());
    if (got.size() > 0) chk("latency", got[0].t - t0, 3 + (9 * OVS + OVS / 2 + 2) * 4);
    expect1("basic", 8'hA5, 1'b0);
    foreach (vecs[i]) begin
      baudDiv = vecs[i].baud;
      send(vecs[i].d, vecs[i].stop, 1'b0, 1'b0);
      drive(1'b1, 2 * bitp());
      expect1($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_u);
    end
    baudDiv = 16'd4;
    drive(1'b0, 20);
    drive(1'b1, 3 * bitp());
    chk("glitch_none", got.size(), 0);
    send(8'h5A, 1'b1, 1'b0, 1'b0);
    drive(1'b1, bitp());
    expect1("after_glitch", 8'h5A, 1'b0);
    send(8'h00, 1'b1, 1'b0, 1'b0);
    send(8'hFF, 1'b1, 1'b0, 1'b0);
    send(8'h55, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2 * bitp());
    chk("b2b_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("b2b_d0", got[0].d, 8'h00);
      chk("b2b_d1", got[1].d, 8'hFF);
      chk("b2b_d2", got[2].d, 8'h55);
      chk("b2b_user", {got[0].u, got[1].u, got[2].u}, 0);
    end
    got.delete();
    drive(1'b0, 30 * bitp());
    expect1("break", 8'h00, 1'b1);
    drive(1'b0, 10 * bitp());
    chk("break_quiet", got.size(), 0);
    drive(1'b1, 2 * bitp());
    chk("break_rise_quiet", got.size(), 0);
    send(8'h3C, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2 * bitp());
    expect1("after_break", 8'h3C, 1'b0);
    d = 8'h81;
    drive(1'b0, bitp());
    for (int i = 0; i < 4; i++) drive(d[i], bitp());
    drive(d[4], bitp() / 2);
    rst = 0;
    #1;
    chk("midrst_tvalid", rx_tvalid, 0);
    chk("midrst_tdata", rx_tdata, 0);
    chk("midrst_tuser", rx_tuser, 0);
    chk("midrst_bit_tick", bit_tick, 0);
    rxd = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    drive(1'b1, 2 * bitp());
    chk("midrst_quiet", got.size(), 0);
    send(8'h81, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2 * bitp());
    expect1("after_rst", 8'h81, 1'b0);
`ifdef GJ_UART_RX_PARITY_EN
    parity_en = 1;
    parity_odd = 1;
    send(8'h03, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 2 * bitp());
    expect1("par_bad", 8'h03, model_user(8'h03, 1'b1, 1'b1, 1'b0, 1'b1));
    send(8'h03, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 2 * bitp());
    expect1("par_good", 8'h03, model_user(8'h03, 1'b1, 1'b1, 1'b1, 1'b1));
    parity_en = 0;
    parity_odd = 0;
`endif
    for (int n = 0; n < 40; n++) begin
      baudDiv = 16'($urandom_range(0, 4));
      d = 8'($urandom);
      stop = $urandom_range(0, 7) != 0;
      gap = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
      send(d, stop, 1'b0, 1'b0);
      expect1($sformatf("rnd%0d", n), d, model_user(d, stop, 1'b0, 1'b0, 1'b0));
      if (gap > 0) drive(1'b1, gap * bitp());
    end
    drive(1'b1, 2 * bitp());
    chk("tail_quiet", got.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gj_axis_uart_rx.md
Name: gj_axis_uart_rx

Overview:
Oversampling UART receiver that turns the serial line into the byte stream (rx_tvalid/rx_tdata/rx_tuser) consumed by the packet-framing stage directly downstream. It also produces the bit-rate enable that the downstream stage uses as its clk_en for inter-byte gap timing. Each byte is one valid pulse. rx_tuser marks a byte received with a parity or framing error.

Parameters:
OVS, 16, oversample ticks per bit; even, 8..32
DBITS, 8, data bits per character; fixed 8 in this release

Ports:
clk  input  1  single clock
rst  input  1  reset, asynchronous assert, active-low
baudDiv  input  16  clk cycles per oversample tick; 0 and 1 both mean one tick every clk
parity_en  input  1  1: expect parity bit after data
parity_odd  input  1  1: odd parity, 0: even parity
rxd  input  1  asynchronous serial line, idle high
rx_tvalid  output  1  one-clk pulse per received character
rx_tdata  output  8  received character, LSB received first; held until next pulse
rx_tuser  output  1  qualified by rx_tvalid; 1 = parity or framing error
bit_tick  output  1  one-clk pulse every OVS oversample ticks, free-running; downstream clk_en

Behaviour:
- Reset (rst=0) values:
  - Outputs: rx_tvalid=0, rx_tdata=0, rx_tuser=0, bit_tick=0.
  - Internal: synchroniser flops=1, FSM=IDLE, all counters=0.
- Input sync: rxd passes through a 2-flop synchroniser (rxs). Edge detection uses rxs and its previous value.
- Prescaler:
  - Down-counter loads max(baudDiv,1)-1.
  - Emits tick when it reaches 0.
  - Free-running; restarts at load value on a start edge in IDLE.
- bit_tick:
  - Separate modulo-OVS counter on tick.
  - Pulses when that counter wraps.
  - Never stops, never resyncs to frames.
- Sampling:
  - Oversample counter sc counts 0..OVS-1 on tick, wrapping at OVS-1.
  - Bit value is the majority of rxs at sc = OVS/2-1, OVS/2 and OVS/2+1.
  - The bit decision is made on the OVS/2+1 tick.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAITHI.
- IDLE: on rxs falling edge, go to START and clear sc.
- START:
  - At decision, majority 1 -> IDLE (glitch rejected, no output).
  - Majority 0 -> DATA with bit index 0.
- DATA:
  - Shift decided bit into bit[index], LSB first.
  - After bit 7, go to PARITY if parity_en, else STOP.
- PARITY:
  - Captured bit is checked against XOR of data.
  - Expected bit = ^data for even parity, ~^data for odd parity.
  - Mismatch sets perr.
  - Then go to STOP.
- STOP:
  - At decision, present the character; perr is ORed with ferr into rx_tuser.
  - Majority 1 -> IDLE.
  - Majority 0 -> set ferr, go to WAITHI.
  - FSM returns to IDLE at mid-stop, so a start edge half a bit later is accepted.
- Output timing:
  - rx_tvalid pulses for exactly one clk, the cycle after the stop decision tick.
  - rx_tdata and rx_tuser are updated in that same cycle.
  - Latency from rxd start edge: 2 clk sync + (1+8+parity_en) bit periods + (OVS/2+2) ticks + 1 clk.
- WAITHI (break / framing recovery): stay until rxs=1, then IDLE. No further characters are produced while the line is low.
- Configuration changes:
  - parity_en, parity_odd and baudDiv are sampled live.
  - Changing them mid-character is undefined; changes in IDLE take effect on the next start edge.
- Reset mid-character: the partial character is discarded and no valid pulse is produced.

Optional Feature:
Macro GJ_UART_RX_PARITY_EN.
- Defined: PARITY state, parity_en and parity_odd are functional, as above.
- Not defined:
  - PARITY state and parity logic are omitted; parity_en and parity_odd remain as ports but are ignored.
  - Frame is fixed 8N1; rx_tuser reflects framing error only.

Test Plan:
- Basic 8N1: baudDiv=4, OVS=16, parity_en=0, send 0xA5 -> single rx_tvalid, rx_tdata=0xA5, rx_tuser=0, latency per formula; bit_tick every 64 clk.
- Start glitch: rxd low for 20 clk (< OVS/2 ticks) then high -> no rx_tvalid, FSM back in IDLE.
- Back-to-back: 0x00, 0xFF, 0x55 with one stop bit and no gap -> three pulses, data in order, rx_tuser=0 on each.
- Parity (macro defined): parity_en=1, parity_odd=1, send 0x03 with parity bit 0 -> 0x03 with rx_tuser=1; resend with parity bit 1 -> rx_tuser=0.
- Break: rxd held low for 3 character times -> exactly one pulse with rx_tdata=0x00 and rx_tuser=1, then none until rxd rises; next 0x3C is received clean.
- Reset mid-frame: assert rst during data bit 4 -> all outputs 0 immediately. After release, a full 0x81 frame produces exactly one valid with 0x81.
